// File: rtl/dbg_pin_router_if.sv
// Debug pin router bus bundle: candidate pin pairs and the debug slave lines.
// The router takes the slave modport; pads and the slave take the master side.
interface dbg_pin_router_if #(
  parameter int NPAIR = 5
);
  logic [NPAIR-1:0] pin_scl_i;
  logic [NPAIR-1:0] pin_sda_i;
  logic [NPAIR-1:0] pin_scl_oe;
  logic [NPAIR-1:0] pin_sda_oe;
  logic             slv_scl_o;
  logic             slv_sda_o;
  logic             slv_scl_i;
  logic             slv_sda_i;

  modport master (
    output pin_scl_i, pin_sda_i, slv_scl_o, slv_sda_o,
    input  pin_scl_oe, pin_sda_oe, slv_scl_i, slv_sda_i
  );

  modport slave (
    input  pin_scl_i, pin_sda_i, slv_scl_o, slv_sda_o,
    output pin_scl_oe, pin_sda_oe, slv_scl_i, slv_sda_i
  );
endinterface

// File: rtl/dbg_pin_router.sv
// Debug pin router: scans NPAIR pin pairs, locks onto the first one showing
// I2C START or UART start-bit activity, and bridges it to the debug slave.
module dbg_pin_router #(
  parameter int NPAIR    = 5,
  parameter int IDX_W    = 3,
  parameter int FLT_N    = 3,
  parameter int TO_W     = 16,
  parameter int TO_CYC   = 48000,
  parameter int UART_MIN = 12
) (
  input  logic               clk,
  input  logic               rstz,
  input  logic               r_en,
  input  logic               r_mode,
  input  logic               r_force,
  input  logic [IDX_W-1:0]   r_fidx,
  input  logic [NPAIR-1:0]   r_pair_en,
  dbg_pin_router_if.slave    bus,
  output logic [IDX_W-1:0]   sel_idx,
  output logic               locked,
  output logic               lock_pls
);
  localparam int NL = 2 * NPAIR;
  localparam int FW = $clog2(FLT_N + 1);
  localparam int UW = $clog2(UART_MIN + 1);

  typedef enum logic [1:0] {IDLE, SCAN, LOCKED} st_t;

  st_t              state, nxt;
  logic [NL-1:0]    pin_in, sy1, sy2, flt;
  logic [FW-1:0]    fcnt [NL];
  logic [NPAIR-1:0] f_scl, f_sda, sda_d;
  logic [UW-1:0]    ucnt [NPAIR];
  logic [NPAIR-1:0] st_i2c, st_uart, st_v;
  logic             det;
  logic [IDX_W-1:0] det_idx, sel_nxt;
  logic             pls_nxt, mode_d, force_d;
  logic             fvalid, sel_scl, sel_sda;
  logic             bus_idle, to_hit;
  logic [TO_W-1:0]  to_cnt;
  logic [NPAIR-1:0] sel_oh, scl_oe_q, sda_oe_q;

  assign pin_in = {bus.pin_sda_i, bus.pin_scl_i};
  assign f_scl  = flt[NPAIR-1:0];
  assign f_sda  = flt[NL-1:NPAIR];

  // 2-FF sync, then a line flips only after FLT_N agreeing samples
  always_ff @(posedge clk) begin
    if (!rstz) begin
      sy1 <= '1;
      sy2 <= '1;
      flt <= '1;
      for (int i = 0; i < NL; i++) fcnt[i] <= '0;
    end else begin
      sy1 <= pin_in;
      sy2 <= sy1;
      for (int i = 0; i < NL; i++) begin
        if (sy2[i] == flt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FLT_N - 1)) begin
          flt[i]  <= sy2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  // SDA history for edge detect and per-pair RX low-run counters
  always_ff @(posedge clk) begin
    if (!rstz) begin
      sda_d <= '1;
      for (int i = 0; i < NPAIR; i++) ucnt[i] <= '0;
    end else begin
      sda_d <= f_sda;
      for (int i = 0; i < NPAIR; i++) begin
        if (f_sda[i])
          ucnt[i] <= '0;
        else if (ucnt[i] != UW'(UART_MIN))
          ucnt[i] <= ucnt[i] + 1'b1;
      end
    end
  end

  // Per-pair start qualifiers; lowest enabled index wins
  always_comb begin
    st_uart = '0;
    det     = 1'b0;
    det_idx = '0;
    for (int i = 0; i < NPAIR; i++)
      st_uart[i] = ~f_sda[i] & (ucnt[i] == UW'(UART_MIN - 1));
    for (int i = NPAIR - 1; i >= 0; i--) begin
      if (st_v[i]) begin
        det     = 1'b1;
        det_idx = IDX_W'(i);
      end
    end
  end

  assign st_i2c   = sda_d & ~f_sda & f_scl;
  assign st_v     = (r_mode ? st_uart : st_i2c) & r_pair_en;
  assign fvalid   = {1'b0, r_fidx} < (IDX_W + 1)'(NPAIR);
  assign sel_scl  = f_scl[sel_idx];
  assign sel_sda  = f_sda[sel_idx];
  assign bus_idle = sel_scl & sel_sda & bus.slv_scl_o & bus.slv_sda_o;
  assign to_hit   = to_cnt >= TO_W'(TO_CYC - 1);

  // Next state, selected pair and lock pulse
  always_comb begin
    nxt     = state;
    sel_nxt = sel_idx;
    pls_nxt = 1'b0;
    if (!r_en) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          nxt = SCAN;
          if (r_force && fvalid) begin
            nxt     = LOCKED;
            sel_nxt = r_fidx;
            pls_nxt = 1'b1;
          end
        end
        SCAN: begin
          if (r_force) begin
            if (fvalid) begin
              nxt     = LOCKED;
              sel_nxt = r_fidx;
              pls_nxt = 1'b1;
            end
          end else if (det) begin
            nxt     = LOCKED;
            sel_nxt = det_idx;
            pls_nxt = 1'b1;
          end
        end
        LOCKED: begin
          if (r_mode != mode_d) begin
            nxt = SCAN;
          end else if (r_force) begin
            if (!fvalid) begin
              nxt = SCAN;
            end else if (r_fidx != sel_idx) begin
              sel_nxt = r_fidx;
              pls_nxt = 1'b1;
            end
          end else if (force_d || !r_pair_en[sel_idx] || to_hit) begin
            nxt = SCAN;
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  // State register and lock status
  always_ff @(posedge clk) begin
    if (!rstz) begin
      state    <= IDLE;
      sel_idx  <= '0;
      lock_pls <= 1'b0;
      mode_d   <= r_mode;
      force_d  <= 1'b0;
    end else begin
      state    <= nxt;
      sel_idx  <= sel_nxt;
      lock_pls <= pls_nxt;
      mode_d   <= r_mode;
      force_d  <= r_force;
    end
  end

  // Idle-bus timeout counter, saturating
  always_ff @(posedge clk) begin
    if (!rstz)
      to_cnt <= '0;
    else if (state != LOCKED || !bus_idle || pls_nxt)
      to_cnt <= '0;
    else if (to_cnt != '1)
      to_cnt <= to_cnt + 1'b1;
  end

  assign sel_oh = NPAIR'(1) << sel_nxt;

  // Registered open-drain enables, cleared on the same edge as release
  always_ff @(posedge clk) begin
    if (!rstz || nxt != LOCKED) begin
      scl_oe_q <= '0;
      sda_oe_q <= '0;
    end else begin
      scl_oe_q <= sel_oh & {NPAIR{~bus.slv_scl_o}};
      sda_oe_q <= r_mode ? '0 : sel_oh & {NPAIR{~bus.slv_sda_o}};
    end
  end

  assign locked         = (state == LOCKED);
  assign bus.pin_scl_oe = scl_oe_q;
  assign bus.pin_sda_oe = sda_oe_q;
  assign bus.slv_scl_i  = locked ? sel_scl : 1'b1;
  assign bus.slv_sda_i  = locked ? sel_sda : 1'b1;
endmodule

// File: doc/dbg_pin_router.md
Name: dbg_pin_router

Overview:
- Parametrised debug-port router between NPAIR candidate pin pairs and one on-chip debug slave (I2C slave or UART engine).
- Candidate pairs cover SCL/SDA, CC2/CC1, CC1/CC2, DN/DP and DP/DN.
- The router scans all enabled pairs and locks onto the first pair that shows valid protocol activity. It then passes that pair through to the slave, and releases it after a bus-idle timeout.
- Generalises the fixed-pair, static-select debug connection to N pairs, auto-detect, two modes and a force override.

Parameters:
- NPAIR, 5: number of candidate pin pairs.
- IDX_W, 3: width of the pair index; must be at least clog2(NPAIR).
- FLT_N, 3: deglitch length in cycles; a filtered line changes only after FLT_N equal consecutive synced samples.
- TO_W, 16: width of the idle-timeout counter.
- TO_CYC, 48000: idle cycles in LOCKED before release (1 ms at 48 MHz).
- UART_MIN, 12: minimum low cycles on RX that qualify a UART start bit.

Ports:
- clk  in  1  system clock.
- rstz  in  1  reset; synchronous, active-low.
- r_en  in  1  router enable; 0 forces IDLE.
- r_mode  in  1  0 = I2C, 1 = UART.
- r_force  in  1  bypass detection; lock onto r_fidx.
- r_fidx  in  IDX_W  forced pair index.
- r_pair_en  in  NPAIR  per-pair scan enable.
- pin_scl_i  in  NPAIR  pair line A (SCL, or UART TX pin) input.
- pin_sda_i  in  NPAIR  pair line B (SDA, or UART RX pin) input.
- pin_scl_oe  out  NPAIR  open-drain pull-low enable, line A.
- pin_sda_oe  out  NPAIR  open-drain pull-low enable, line B.
- slv_scl_o  in  1  slave SCL drive (0 = pull low), or UART TX.
- slv_sda_o  in  1  slave SDA drive (0 = pull low).
- slv_scl_i  out  1  filtered SCL to the slave.
- slv_sda_i  out  1  filtered SDA, or UART RX, to the slave.
- sel_idx  out  IDX_W  locked pair index.
- locked  out  1  a pair is connected.
- lock_pls  out  1  one-cycle pulse on each entry to LOCKED.

Behaviour:
- Reset (rstz=0 at a clk edge):
  - state = IDLE, sel_idx = 0, locked = 0, lock_pls = 0.
  - pin_*_oe = 0.
  - slv_scl_i = slv_sda_i = 1.
  - Sync and filter registers are loaded with 1; timeout counter = 0.
- Input conditioning: every pin input passes through a 2-FF synchroniser and then the FLT_N filter. Pin-to-filtered latency is 2+FLT_N cycles.
- States:
  - IDLE: entered when r_en=0. Exits to SCAN when r_en=1 and r_force=0, or to LOCKED when r_en=1 and r_force=1 with a valid r_fidx.
  - SCAN:
    - I2C mode: a start is SDA filtered 1→0 while SCL filtered = 1 on an enabled pair.
    - UART mode: a start is SDA (RX) filtered low for UART_MIN consecutive cycles on an enabled pair.
    - On the first detected start: sel_idx takes that index, go to LOCKED, lock_pls = 1.
    - Simultaneous starts: lowest index wins.
  - LOCKED:
    - slv_scl_i and slv_sda_i take the filtered lines of sel_idx.
    - I2C: pin_sda_oe[sel] = ~slv_sda_o and pin_scl_oe[sel] = ~slv_scl_o.
    - UART: pin_scl_oe[sel] = ~slv_scl_o (TX); pin_sda_oe stays 0.
    - All non-selected oe bits = 0.
    - Output enables are registered (1 cycle from slv_*_o).
- Detection latency: locked rises one cycle after the qualifying filtered edge (I2C) or after the UART_MIN-th low cycle (UART).
- Timeout:
  - The counter increments in LOCKED while both filtered lines of the selected pair are 1 and the slave's own drives are released.
  - Any low clears it.
  - Reaching TO_CYC-1 returns the router to SCAN with locked=0 and all oe=0.
  - The counter saturates and never wraps.
- Immediate release to SCAN (next cycle, regardless of bus state) occurs when:
  - r_pair_en[sel_idx] drops to 0 with r_force=0;
  - r_mode changes;
  - r_en=0, which goes to IDLE instead of SCAN.
- Force mode:
  - r_force=1 locks onto r_fidx, ignores r_pair_en, and disables the timeout.
  - r_fidx ≥ NPAIR gives locked=0 and the router is held in SCAN with no detection.
  - A change of r_fidx while forced re-locks with a new lock_pls.
  - r_force 1→0 goes to SCAN.
- Slave side outside LOCKED: slv_*_i = 1, so the slave sees an idle bus. No lock_pls is generated on release.
- Reset mid-transaction: all outputs revert to reset values on the same edge; pins are released immediately.

Test Plan:
- I2C auto-lock: r_pair_en=5'b11111, START on pair 3 → locked=1, sel_idx=3 and lock_pls high for one cycle at 2+FLT_N+1 cycles after the SDA fall. Slave ACK (slv_sda_o=0) → pin_sda_oe=5'b01000.
- Glitch reject and priority: a 2-cycle SDA low pulse on pair 1 → no lock. Simultaneous STARTs on pairs 2 and 4 → sel_idx=2.
- Timeout: after a STOP on the locked pair with bus idle for TO_CYC=100 (test override) cycles → locked=0, oe=0. A subsequent START on pair 0 → sel_idx=0.
- UART mode: RX on pair 4 low for 11 cycles → no lock. Low for 12 cycles → locked=1, sel_idx=4. slv_scl_o toggling → pin_scl_oe[4] follows, inverted, one cycle later.
- Force: r_force=1, r_fidx=1 with r_pair_en[1]=0 → locked next cycle and no timeout after 2×TO_CYC idle. r_fidx=7 → locked=0.
- Mid-operation disturbance: clearing r_pair_en[sel] → release next cycle. Asserting rstz=0 while pin_sda_oe is active → all oe=0 and slv_*_i=1 on that edge.
